// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake for the queued UART transmitter: a word is
// transferred on a rising edge where valid and ready are both high.
interface uart_tx_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: frames are start, data LSB first,
// optional parity and one or two stop bits, sent back-to-back when queued.
module uart_tx_fifo #(
  parameter int WIDTH     = 8,
  parameter int CLKDIV    = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  uart_tx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   active_o,
  output logic                   sent_o,
  output logic                   tx_o
);

  localparam int AW         = $clog2(DEPTH);
  localparam int FRAME_BITS = 1 + WIDTH + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = $clog2(CLKDIV);

  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLKDIV - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [AW-1:0]         wrPtr_q, wrPtr_d;
  logic [AW-1:0]         rdPtr_q, rdPtr_d;
  logic [AW:0]           level_q, level_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [BW-1:0]         bitCnt_q, bitCnt_d;
  logic [DW-1:0]         divCnt_q, divCnt_d;
  logic                  active_q, active_d;
  logic                  sent_q, sent_d;

  logic                  push;
  logic                  pop;
  logic [WIDTH-1:0]      head;
  logic                  parityBit;
  logic [FRAME_BITS-1:0] loadFrame;

  assign bus.ready = (level_q != FULL);
  assign push      = bus.valid && bus.ready;
  assign head      = mem_q[rdPtr_q];

  // Whole frame is staged at pop time; bit 0 is the line, ones refill from the top.
  always_comb begin
    parityBit = (PARITY == 1) ? ~(^head) : (^head);
    loadFrame = '1;
    loadFrame[0] = 1'b0;
    loadFrame[WIDTH:1] = head;
    if (PARITY != 0) begin
      loadFrame[WIDTH+1] = parityBit;
    end
  end

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bitCnt_d = bitCnt_q;
    divCnt_d = divCnt_q;
    sent_d   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop      = 1'b1;
          frame_d  = loadFrame;
          bitCnt_d = '0;
          divCnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (divCnt_q == LAST_DIV) begin
          divCnt_d = '0;
          if (bitCnt_q == LAST_BIT) begin
            sent_d = 1'b1;
            // A queued word starts its start bit on this very edge, no idle gap.
            if (level_q != '0) begin
              pop      = 1'b1;
              frame_d  = loadFrame;
              bitCnt_d = '0;
            end else begin
              frame_d = '1;
              state_d = IDLE;
            end
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
            frame_d  = {1'b1, frame_q[FRAME_BITS-1:1]};
          end
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        frame_d = '1;
      end
    endcase
    active_d = (state_d == SHIFT);
  end

  always_comb begin
    wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      mem_q[wrPtr_q] <= bus.data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      frame_q  <= '1;
      bitCnt_q <= '0;
      divCnt_q <= '0;
      active_q <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      level_q  <= level_d;
      frame_q  <= frame_d;
      bitCnt_q <= bitCnt_d;
      divCnt_q <= divCnt_d;
      active_q <= active_d;
      sent_q   <= sent_d;
    end
  end

  assign level_o  = level_q;
  assign active_o = active_q;
  assign sent_o   = sent_q;
  assign tx_o     = frame_q[0];

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (no parity, even, odd, two stop bits)
// checked every cycle against a queue-level model, plus directed frame tables.
module tb_uart_tx_fifo;

  localparam int NDUT   = 4;
  localparam int CLKDIV = 4;
  localparam int DEPTH  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NDUT-1:0]      validV = '0;
  logic [7:0]           dataV [NDUT];
  logic [NDUT-1:0]      readyV, activeV, sentV, txV;
  logic [NDUT-1:0][2:0] levelV;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    uart_tx_fifo_if #(.WIDTH(8)) bus ();
    assign bus.data  = dataV[g];
    assign bus.valid = validV[g];
    assign readyV[g] = bus.ready;

    uart_tx_fifo #(
      .WIDTH    (8),
      .CLKDIV   (CLKDIV),
      .PARITY   ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
      .STOP_BITS((g == 3) ? 2 : 1),
      .DEPTH    (DEPTH)
    ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .bus     (bus),
      .level_o (levelV[g]),
      .active_o(activeV[g]),
      .sent_o  (sentV[g]),
      .tx_o    (txV[g])
    );
  end

  function automatic int parOf(input int g);
    return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
  endfunction

  function automatic int stopOf(input int g);
    return (g == 3) ? 2 : 1;
  endfunction

  function automatic int frameLen(input int g);
    return (1 + 8 + ((parOf(g) != 0) ? 1 : 0) + stopOf(g)) * CLKDIV;
  endfunction

  function automatic logic expBit(input int g, input logic [7:0] w, input int idx);
    int ones;
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (parOf(g) != 0 && idx == 9) begin
      for (int i = 0; i < 8; i++) ones += (w[i] ? 1 : 0);
      return (parOf(g) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int g, input logic [7:0] d);
    validV[g] = 1'b1;
    dataV[g]  = d;
    @(negedge clk);
    validV[g] = 1'b0;
  endtask

  // Model: FIFO contents as an array, the transmitter as "cycles left in frame".
  logic [7:0] mBuf [NDUT][DEPTH];
  int         mCnt [NDUT] = '{default: 0};
  int         mRem [NDUT] = '{default: 0};
  logic       mBusy[NDUT] = '{default: 1'b0};
  logic       mSent[NDUT] = '{default: 1'b0};
  logic [7:0] mCur [NDUT] = '{default: 8'h00};

  task automatic modelStep(input int g);
    bit doPop;
    bit doAccept;
    doAccept = validV[g] && (mCnt[g] != DEPTH);
    doPop = 1'b0;
    if (!rst_n) begin
      mCnt[g]  = 0;
      mBusy[g] = 1'b0;
      mSent[g] = 1'b0;
      mRem[g]  = 0;
      return;
    end
    mSent[g] = 1'b0;
    if (mBusy[g]) begin
      mRem[g]--;
      if (mRem[g] == 0) begin
        mSent[g] = 1'b1;
        if (mCnt[g] > 0) doPop = 1'b1;
        else mBusy[g] = 1'b0;
      end
    end else if (mCnt[g] > 0) begin
      doPop = 1'b1;
    end
    if (doPop) begin
      mCur[g] = mBuf[g][0];
      for (int i = 0; i < DEPTH - 1; i++) mBuf[g][i] = mBuf[g][i+1];
      mCnt[g]--;
      mBusy[g] = 1'b1;
      mRem[g]  = frameLen(g);
    end
    if (doAccept) begin
      mBuf[g][mCnt[g]] = dataV[g];
      mCnt[g]++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int g = 0; g < NDUT; g++) begin
      logic expTx;
      modelStep(g);
      expTx = mBusy[g] ? expBit(g, mCur[g], (frameLen(g) - mRem[g]) / CLKDIV) : 1'b1;
      checkOutput($sformatf("model level[%0d]", g), 32'(levelV[g]), mCnt[g]);
      checkOutput($sformatf("model ready[%0d]", g), 32'(readyV[g]), 32'(mCnt[g] != DEPTH));
      checkOutput($sformatf("model active[%0d]", g), 32'(activeV[g]), 32'(mBusy[g]));
      checkOutput($sformatf("model sent[%0d]", g), 32'(sentV[g]), 32'(mSent[g]));
      checkOutput($sformatf("model tx[%0d]", g), 32'(txV[g]), 32'(expTx));
    end
  end

  typedef struct {
    int          dut;
    logic [7:0]  data;
    int          nBits;
    logic [15:0] expBits;
    int          expLen;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 10, 16'({1'b1, 8'hA5, 1'b0}), 40};
    vecs[1] = '{1, 8'h07, 11, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 44};
    vecs[2] = '{2, 8'h07, 11, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 44};
    vecs[3] = '{2, 8'h00, 11, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 44};
    vecs[4] = '{1, 8'h00, 11, 16'({1'b1, 1'b0, 8'h00, 1'b0}), 44};
    vecs[5] = '{3, 8'h3C, 11, 16'({2'b11, 8'h3C, 1'b0}), 44};
    for (int g = 0; g < NDUT; g++) dataV[g] = 8'h00;

    tick(3);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("reset level[%0d]", g), 32'(levelV[g]), 0);
      checkOutput($sformatf("reset ready[%0d]", g), 32'(readyV[g]), 1);
      checkOutput($sformatf("reset active[%0d]", g), 32'(activeV[g]), 0);
      checkOutput($sformatf("reset sent[%0d]", g), 32'(sentV[g]), 0);
      checkOutput($sformatf("reset tx[%0d]", g), 32'(txV[g]), 1);
    end
    rst_n = 1'b1;
    tick(2);

    $display("[TB] single-frame table");
    for (int i = 0; i < 6; i++) begin
      vec_t        e;
      logic [63:0] trace;
      int          actCnt;
      int          sentAt;
      int          g;
      e = vecs[i];
      g = e.dut;
      trace = '1;
      actCnt = 0;
      sentAt = -1;
      applyStimulus(g, e.data);
      checkOutput($sformatf("vec%0d latency level", i), 32'(levelV[g]), 1);
      checkOutput($sformatf("vec%0d latency active", i), 32'(activeV[g]), 0);
      tick(1);
      for (int k = 0; k < e.expLen + 4; k++) begin
        trace[k] = txV[g];
        if (activeV[g]) actCnt++;
        if (sentV[g] && sentAt < 0) sentAt = k;
        tick(1);
      end
      checkOutput($sformatf("vec%0d active cycles", i), actCnt, e.expLen);
      checkOutput($sformatf("vec%0d sent offset", i), sentAt, e.expLen);
      for (int b = 0; b < e.nBits; b++)
        checkOutput($sformatf("vec%0d bit%0d", i, b), 32'(trace[b*CLKDIV +: CLKDIV]),
                    32'({CLKDIV{e.expBits[b]}}));
      checkOutput($sformatf("vec%0d idle after", i), 32'(trace[e.expLen]), 1);
    end

    $display("[TB] burst of six valid cycles into a depth-4 FIFO");
    begin
      int acc;
      int w;
      acc = 0;
      for (int k = 0; k < 6; k++) begin
        validV[0] = 1'b1;
        dataV[0]  = 8'h10 + 8'(k);
        if (readyV[0]) acc++;
        tick(1);
      end
      validV[0] = 1'b0;
      checkOutput("burst accepted", acc, 5);
      checkOutput("burst full level", 32'(levelV[0]), 4);
      checkOutput("burst full ready", 32'(readyV[0]), 0);
      for (int j = 0; j < 5; j++) begin
        w = 0;
        while (!sentV[0] && w < 100) begin
          tick(1);
          w++;
        end
        checkOutput($sformatf("burst sent%0d spacing", j), w, (j == 0) ? 36 : 39);
        checkOutput($sformatf("burst level after frame%0d", j), 32'(levelV[0]),
                    (j < 4) ? 3 - j : 0);
        checkOutput($sformatf("burst active after frame%0d", j), 32'(activeV[0]),
                    (j < 4) ? 1 : 0);
        tick(1);
      end
    end

    $display("[TB] back-to-back frames with two stop bits");
    begin
      logic [95:0] txT;
      int          drops;
      int          nSent;
      int          sentPos[4];
      drops = 0;
      nSent = 0;
      sentPos = '{default: -1};
      validV[3] = 1'b1;
      dataV[3]  = 8'h00;
      tick(1);
      dataV[3]  = 8'hFF;
      tick(1);
      validV[3] = 1'b0;
      for (int k = 0; k < 92; k++) begin
        txT[k] = txV[3];
        if (!activeV[3] && k < 88) drops++;
        if (sentV[3] && nSent < 4) begin
          sentPos[nSent] = k;
          nSent++;
        end
        tick(1);
      end
      checkOutput("b2b active drops", drops, 0);
      checkOutput("b2b sent count", nSent, 2);
      checkOutput("b2b first sent", sentPos[0], 44);
      checkOutput("b2b second sent", sentPos[1], 88);
      checkOutput("b2b last stop bit", 32'(txT[43]), 1);
      checkOutput("b2b next start bit", 32'(txT[44]), 0);
      checkOutput("b2b idle after", 32'(txT[88]), 1);
    end

    $display("[TB] reset in the middle of a frame");
    begin
      int busyCycles;
      busyCycles = 0;
      validV[0] = 1'b1;
      dataV[0]  = 8'h55;
      tick(1);
      dataV[0]  = 8'h66;
      tick(1);
      dataV[0]  = 8'h77;
      tick(1);
      validV[0] = 1'b0;
      tick(10);
      checkOutput("pre-reset level", 32'(levelV[0]), 2);
      checkOutput("pre-reset active", 32'(activeV[0]), 1);
      rst_n = 1'b0;
      tick(1);
      checkOutput("mid-reset tx", 32'(txV[0]), 1);
      checkOutput("mid-reset active", 32'(activeV[0]), 0);
      checkOutput("mid-reset level", 32'(levelV[0]), 0);
      checkOutput("mid-reset ready", 32'(readyV[0]), 1);
      rst_n = 1'b1;
      for (int k = 0; k < 100; k++) begin
        if (activeV[0] || !txV[0]) busyCycles++;
        tick(1);
      end
      checkOutput("post-reset silence", busyCycles, 0);
    end

    $display("[TB] write coinciding with frame-end pop");
    begin
      logic [119:0] txT;
      logic [7:0]   got;
      logic [7:0]   expWord[3];
      expWord = '{8'h82, 8'h83, 8'h84};
      validV[0] = 1'b1;
      dataV[0]  = 8'h81;
      tick(1);
      dataV[0]  = 8'h82;
      tick(1);
      dataV[0]  = 8'h83;
      tick(1);
      validV[0] = 1'b0;
      tick(38);
      checkOutput("coincide level before", 32'(levelV[0]), 2);
      validV[0] = 1'b1;
      dataV[0]  = 8'h84;
      tick(1);
      validV[0] = 1'b0;
      checkOutput("coincide level after", 32'(levelV[0]), 2);
      checkOutput("coincide sent", 32'(sentV[0]), 1);
      checkOutput("coincide active", 32'(activeV[0]), 1);
      for (int k = 0; k < 120; k++) begin
        txT[k] = txV[0];
        tick(1);
      end
      for (int f = 0; f < 3; f++) begin
        got = '0;
        for (int b = 0; b < 8; b++) got[b] = txT[f*40 + (b+1)*CLKDIV + CLKDIV/2];
        checkOutput($sformatf("coincide frame%0d word", f), 32'(got), 32'(expWord[f]));
      end
      tick(60);
    end

    $display("[TB] randomized traffic against the model");
    for (int c = 0; c < 3000; c++) begin
      int dens;
      dens = ((c / 500) % 3 == 0) ? 4 : (((c / 500) % 3 == 1) ? 30 : 90);
      for (int g = 0; g < NDUT; g++) begin
        validV[g] = ($urandom_range(0, 99) < dens);
        dataV[g]  = 8'($urandom);
      end
      rst_n = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    validV = '0;
    rst_n = 1'b1;
    tick(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter for the serial-output path. It is the next generation of the basic shift-register transmitter. Adds configurable data width, optional parity, 1 or 2 stop bits, and an input FIFO with a valid/ready handshake so producers can queue several words. Frames leave back-to-back on a single tx line, LSB first, idle-high.

Parameters:
WIDTH, 8, data bits per frame (5..16)
CLKDIV, 16, clock cycles per bit period (>=2)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
data  in  WIDTH  word to transmit
valid  in  1  data is presented this cycle
ready  out  1  FIFO can accept; transfer occurs on an edge where valid && ready
level  out  $clog2(DEPTH)+1  words currently held in FIFO (excludes the word being shifted)
active  out  1  a frame is being shifted out
sent  out  1  one-cycle pulse at the end of each frame
tx  out  1  serial line

Behaviour:
- Reset (rst_n low at a rising edge): FIFO flushed, level=0, ready=1, active=0, sent=0, tx=1, bit counter and divider cleared. Reset mid-frame aborts the frame; tx is 1 from the next cycle.
- FIFO: ready = (level != DEPTH), registered-free (combinational from level).
  - Write while full is ignored; ready is low, so no transfer occurs.
  - Pointers wrap modulo DEPTH.
  - level updates on the edge after a write or pop; a simultaneous write and pop leaves level unchanged.
- Frame format: start(0), data[0]..data[WIDTH-1], parity bit if PARITY!=0, STOP_BITS × 1.
  - Odd parity: the total count of 1s in data and parity is odd. Even parity: that total is even.
- Frame length = (1 + WIDTH + (PARITY!=0) + STOP_BITS) × CLKDIV cycles. Each bit holds exactly CLKDIV cycles.
- State machine: IDLE, SHIFT.
  - IDLE: tx=1 and active=0. If level != 0, pop the head into the shift register, compute parity, clear the divider, and move to SHIFT.
  - SHIFT: active=1, and tx is driven by the register output. The divider counts 0..CLKDIV-1, and the register advances when the divider reaches CLKDIV-1.
  - After the last stop bit period:
    - sent pulses for 1 cycle.
    - If the FIFO is non-empty, pop on that same edge and start the next start bit immediately, with no idle gap and active held high.
    - Otherwise return to IDLE.
- Latency with an idle, empty block: valid accepted at edge E, level=1 after E, pop at E+1, start bit on tx from E+1 (tx low for cycles E+1..E+CLKDIV).
- tx, active and sent are registered outputs, glitch-free.
- The data input is sampled only at the accept edge; later changes do not affect queued words.

Test Plan:
1. WIDTH=8, CLKDIV=4, PARITY=0, STOP_BITS=1; send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 total); sent pulses once, 40 cycles after the start bit begins; active is high for exactly 40 cycles.
2. PARITY=2, send 0x07 -> parity bit 1. PARITY=1, send 0x07 -> parity bit 0. PARITY=1, send 0x00 -> parity bit 1. Each frame is 44 cycles at CLKDIV=4.
3. DEPTH=4; hold valid for 6 consecutive cycles while the first frame starts -> 5 words accepted (1 popped, then 4 queued). ready drops when level=4. All 5 frames are sent in order, and level decrements once per frame start.
4. Queue 0x00 then 0xFF, STOP_BITS=2 -> second start bit directly follows the 2nd stop bit of the first frame with no idle cycles; active never drops between frames; sent pulses twice, 44 cycles apart.
5. Reset asserted mid-data-bit of frame 1 with 2 words queued -> tx=1, active=0, level=0 and ready=1 on the next cycle; nothing is transmitted after reset is released until new writes.
6. Simultaneous write and frame-end pop with level=2 -> level stays 2, and the written word is transmitted last.
